// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter slice.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [5:0] STARVE_MAX = 6'd63;

  // Saturating increment for the instruction-starvation counter.
  function automatic logic [5:0] starve_inc(input logic [5:0] v);
    return (v == STARVE_MAX) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Requester, spi_master and chip-select signals shared by the arbiter.
// master = front-ends plus spi_master side, slave = the arbiter itself.
interface spi_bus_arbiter_if;

  logic        i_req;
  logic [31:0] i_cmd_addr;
  logic [5:0]  i_len;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_cmd_addr;
  logic [5:0]  d_len;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        spi_start;
  logic        spi_write_enable;
  logic [31:0] spi_cmd_addr;
  logic [5:0]  spi_data_len;
  logic [31:0] spi_data_in;
  logic [31:0] spi_data_out;
  logic        spi_done;
  logic        spi_cs_n;

  logic        flash_cs_n;
  logic        ram_cs_n;
  logic        busy;

  modport master (
    output i_req, i_cmd_addr, i_len,
    input  i_ack, i_rdata,
    output d_req, d_we, d_cmd_addr, d_len, d_wdata,
    input  d_ack, d_rdata,
    input  spi_start, spi_write_enable, spi_cmd_addr, spi_data_len, spi_data_in,
    output spi_data_out, spi_done, spi_cs_n,
    input  flash_cs_n, ram_cs_n, busy
  );

  modport slave (
    input  i_req, i_cmd_addr, i_len,
    output i_ack, i_rdata,
    input  d_req, d_we, d_cmd_addr, d_len, d_wdata,
    output d_ack, d_rdata,
    output spi_start, spi_write_enable, spi_cmd_addr, spi_data_len, spi_data_in,
    input  spi_data_out, spi_done, spi_cs_n,
    output flash_cs_n, ram_cs_n, busy
  );

endinterface

// File: rtl/spi_arb_select.sv
// Winner selection between instruction and data ports, plus the
// starvation counter value to load when a grant is taken.
module spi_arb_select
  import spi_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic       i_elig,
  input  logic       d_elig,
  input  logic       i_req,
  input  logic [5:0] starve_cnt,
  output logic       grant_i,
  output logic       grant_d,
  output logic [5:0] starve_nxt
);

  logic aged;

  // A streak limit of zero means strict data priority, so aging never fires.
  generate
    if (MAX_DATA_STREAK == 0) begin : g_no_aging
      assign aged = 1'b0;
    end else begin : g_aging
      assign aged = (32'(starve_cnt) >= MAX_DATA_STREAK);
    end
  endgenerate

  // Data wins ties unless instruction has waited out the allowed streak.
  always_comb begin
    grant_i = i_elig && (!d_elig || aged);
    grant_d = d_elig && !grant_i;
  end

  // Count data grants taken while an instruction request is waiting.
  always_comb begin
    starve_nxt = starve_cnt;
    if (grant_d && i_req) begin
      starve_nxt = starve_inc(starve_cnt);
    end else if (grant_i || grant_d) begin
      starve_nxt = 6'd0;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one spi_master between the instruction (flash) and data (RAM)
// requesters, with data priority, bounded instruction starvation and a
// chip-select guard gap after every transfer.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | no transfer; pick a winner and latch its payload
//   ST_ISSUE | spi_start pulse to spi_master
//   ST_BUSY  | waiting for spi_done; ack + rdata registered on done
//   ST_GUARD | CS guard gap, owner still held so CS routing is stable
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input logic               clk,
  input logic               rst,
  spi_bus_arbiter_if.slave  bus
);

  localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);

  arb_state_t  state;
  owner_t      owner;
  logic [5:0]  starve_cnt;
  logic [7:0]  gap_cnt;

  logic        start_q;
  logic        we_q;
  logic [31:0] cmd_addr_q;
  logic [5:0]  len_q;
  logic [31:0] data_in_q;
  logic        i_ack_q;
  logic        d_ack_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic        i_elig;
  logic        d_elig;
  logic        grant_i;
  logic        grant_d;
  logic [5:0]  starve_nxt;

  // A port whose ack is high this cycle still shows its old request; skip it.
  assign i_elig = bus.i_req && !i_ack_q;
  assign d_elig = bus.d_req && !d_ack_q;

  spi_arb_select #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_select (
    .i_elig     (i_elig),
    .d_elig     (d_elig),
    .i_req      (bus.i_req),
    .starve_cnt (starve_cnt),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .starve_nxt (starve_nxt)
  );

  // Transfer sequencer: grant, start pulse, wait for done, ack, guard gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= 6'd0;
      gap_cnt    <= 8'd0;
      start_q    <= 1'b0;
      we_q       <= 1'b0;
      cmd_addr_q <= 32'd0;
      len_q      <= 6'd0;
      data_in_q  <= 32'd0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      start_q <= 1'b0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_i || grant_d) begin
            starve_cnt <= starve_nxt;
            start_q    <= 1'b1;
            state      <= ST_ISSUE;
            if (grant_d) begin
              owner      <= OWN_DATA;
              we_q       <= bus.d_we;
              cmd_addr_q <= bus.d_cmd_addr;
              len_q      <= bus.d_len;
              data_in_q  <= bus.d_wdata;
            end else begin
              owner      <= OWN_INSTR;
              we_q       <= 1'b0;
              cmd_addr_q <= bus.i_cmd_addr;
              len_q      <= bus.i_len;
              data_in_q  <= 32'd0;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (bus.spi_done) begin
            if (owner == OWN_DATA) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= bus.spi_data_out;
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= bus.spi_data_out;
            end
            if (GAP_INIT == 8'd0) begin
              state <= ST_IDLE;
              owner <= OWN_NONE;
            end else begin
              state   <= ST_GUARD;
              gap_cnt <= GAP_INIT;
            end
          end
        end
        ST_GUARD: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign bus.spi_start        = start_q;
  assign bus.spi_write_enable = we_q;
  assign bus.spi_cmd_addr     = cmd_addr_q;
  assign bus.spi_data_len     = len_q;
  assign bus.spi_data_in      = data_in_q;
  assign bus.i_ack            = i_ack_q;
  assign bus.d_ack            = d_ack_q;
  assign bus.i_rdata          = i_rdata_q;
  assign bus.d_rdata          = d_rdata_q;
  assign bus.busy             = (state != ST_IDLE);

  // Route the single spi_master chip select to whichever device owns the bus.
  assign bus.flash_cs_n = (owner == OWN_INSTR) ? bus.spi_cs_n : 1'b1;
  assign bus.ram_cs_n   = (owner == OWN_DATA)  ? bus.spi_cs_n : 1'b1;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: scoreboard of expected grants,
// simple spi_master responder, and a strict-priority second instance.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  localparam logic [31:0] MAGIC  = 32'h1000_0040;
  localparam logic [31:0] I_CMD  = {CMD_READ, 24'h000040};
  localparam logic [31:0] D_CMD2 = {CMD_READ, 24'h000200};
  localparam logic [31:0] D_CMD4 = {CMD_READ, 24'h000300};
  localparam logic [31:0] D_CMD5 = {CMD_READ, 24'h000500};
  localparam logic [31:0] D_CMD6 = {CMD_READ, 24'h000600};
  localparam logic [31:0] D_CMD7 = {CMD_READ, 24'h000700};

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] cmd;
    logic [5:0]  len;
    logic [31:0] wdata;
  } xfer_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_bus_arbiter_if bus();
  spi_bus_arbiter_if b2();

  spi_bus_arbiter #(.MAX_DATA_STREAK(4), .GAP_CYCLES(2)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );

  spi_bus_arbiter #(.MAX_DATA_STREAK(0), .GAP_CYCLES(1)) dut_strict (
    .clk (clk), .rst (rst), .bus (b2.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // spi_master model for the main instance: done 3 cycles after start.
  logic m_done = 1'b0;
  logic extra_done = 1'b0;
  int   m_cnt = 0;
  assign bus.spi_done = m_done | extra_done;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_done = 1'b0; m_cnt = 0; bus.spi_cs_n = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          bus.spi_data_out = bus.spi_cmd_addr ^ MAGIC;
          bus.spi_cs_n = 1'b1;
        end
      end else if (bus.spi_start) begin
        bus.spi_cs_n = 1'b0;
        m_cnt = 3;
      end
    end
  end

  // spi_master model for the strict instance: done 2 cycles after start.
  int m2_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      b2.spi_done = 1'b0; m2_cnt = 0; b2.spi_cs_n = 1'b1;
    end else begin
      b2.spi_done = 1'b0;
      if (m2_cnt != 0) begin
        m2_cnt--;
        if (m2_cnt == 0) begin
          b2.spi_done = 1'b1;
          b2.spi_data_out = b2.spi_cmd_addr ^ MAGIC;
          b2.spi_cs_n = 1'b1;
        end
      end else if (b2.spi_start) begin
        b2.spi_cs_n = 1'b0;
        m2_cnt = 2;
      end
    end
  end

  // Scoreboard monitor for the main instance.
  xfer_t exp_q[$];
  xfer_t pend;
  xfer_t mon_e;
  bit    pend_v = 1'b0;
  int    cyc = 0, done_cyc = -10, start_cnt = 0, last_start_cyc = 0;
  int    last_ack_cyc = 0, ack_cnt = 0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      pend_v = 1'b0;
    end else begin
      if (bus.spi_done) done_cyc = cyc;
      if (bus.spi_start) begin
        start_cnt++;
        last_start_cyc = cyc;
        check_eq("start_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("start_cmd_addr", 64'(bus.spi_cmd_addr), 64'(mon_e.cmd));
          check_eq("start_we_len", 64'({bus.spi_write_enable, bus.spi_data_len}),
                   64'({mon_e.we, mon_e.len}));
          check_eq("start_data_in", 64'(bus.spi_data_in),
                   64'(mon_e.is_d ? mon_e.wdata : 32'd0));
          pend   = mon_e;
          pend_v = 1'b1;
        end
      end
      if (bus.i_ack || bus.d_ack) begin
        last_ack_cyc = cyc;
        ack_cnt++;
        check_eq("ack_expected", 64'(pend_v), 64'd1);
        check_eq("ack_port", 64'({bus.i_ack, bus.d_ack}),
                 64'(pend.is_d ? 2'b01 : 2'b10));
        check_eq("ack_latency", 64'(cyc), 64'(done_cyc + 1));
        if (pend_v && !pend.we)
          check_eq("ack_rdata", 64'(pend.is_d ? bus.d_rdata : bus.i_rdata),
                   64'(pend.cmd ^ MAGIC));
        pend_v = 1'b0;
      end
    end
  end

  // Grant counter for the strict instance.
  int i2_starts = 0, d2_starts = 0, i2_acks = 0;
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (b2.spi_start) begin
        if (b2.spi_cmd_addr == I_CMD) i2_starts++;
        else d2_starts++;
      end
      if (b2.i_ack) i2_acks++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_x(input bit is_d, input bit we, input logic [31:0] cmd,
                        input logic [5:0] len, input logic [31:0] wdata);
    xfer_t x;
    x.is_d = is_d; x.we = we; x.cmd = cmd; x.len = len; x.wdata = wdata;
    exp_q.push_back(x);
  endtask

  task automatic wait_ack(input string tag, input bit is_d, input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = is_d ? bus.d_ack : bus.i_ack;
    end
    check_eq(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && start_cnt < n; k++) @(negedge clk);
    check_eq(tag, 64'(start_cnt >= n), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      ok = !bus.busy && !pend_v && (exp_q.size() == 0);
    end
    check_eq(tag, 64'(ok), 64'd1);
  endtask

  int base, ack0, a_cyc;

  initial begin
    bus.i_req = 0; bus.i_cmd_addr = 0; bus.i_len = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_cmd_addr = 0; bus.d_len = 0; bus.d_wdata = 0;
    bus.spi_data_out = 0; bus.spi_cs_n = 1;
    b2.i_req = 0; b2.i_cmd_addr = 0; b2.i_len = 0;
    b2.d_req = 0; b2.d_we = 0; b2.d_cmd_addr = 0; b2.d_len = 0; b2.d_wdata = 0;
    b2.spi_data_out = 0; b2.spi_cs_n = 1; b2.spi_done = 0;

    // Reset state
    tick(3);
    check_eq("rst_regs", 64'({bus.spi_start, bus.spi_write_enable, bus.spi_data_len,
                              bus.i_ack, bus.d_ack, bus.busy}), 64'd0);
    check_eq("rst_cmd_data", {bus.spi_cmd_addr, bus.spi_data_in}, 64'd0);
    check_eq("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
    check_eq("rst_cs", 64'({bus.flash_cs_n, bus.ram_cs_n}), 64'b11);
    rst = 1'b0;
    tick(2);

    // Data write only
    push_x(1, 1, 32'h0200_0100, 6'd32, 32'hDEAD_BEEF);
    bus.d_req = 1; bus.d_we = 1; bus.d_cmd_addr = 32'h0200_0100;
    bus.d_len = 6'd32; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("t1_start_latency", 64'(bus.spi_start), 64'd1);
    check_eq("t1_cs_route", 64'({bus.flash_cs_n, bus.ram_cs_n, bus.spi_cs_n}), 64'b100);
    @(negedge clk);
    check_eq("t1_start_one_cycle", 64'(bus.spi_start), 64'd0);
    wait_ack("t1_d_ack", 1, 20);
    bus.d_req = 0; bus.d_we = 0;
    wait_idle("t1_idle", 20);

    // Instruction read, then gap before the next start
    push_x(0, 0, I_CMD, 6'd32, 32'd0);
    bus.i_req = 1; bus.i_cmd_addr = I_CMD; bus.i_len = 6'd32;
    base = start_cnt;
    wait_starts("t2_i_start", base + 1, 10);
    @(negedge clk);
    push_x(1, 0, D_CMD2, 6'd16, 32'd0);
    bus.d_req = 1; bus.d_cmd_addr = D_CMD2; bus.d_len = 6'd16; bus.d_wdata = 0;
    wait_ack("t2_i_ack", 0, 20);
    check_eq("t2_i_rdata", 64'(bus.i_rdata), 64'h1300_0000);
    bus.i_req = 0;
    wait_starts("t2_d_start", base + 2, 20);
    tick(1);
    check_eq("t2_gap", 64'(last_start_cyc - last_ack_cyc), 64'(3));
    wait_ack("t2_d_ack", 1, 20);
    bus.d_req = 0;
    tick(1);
    check_eq("t2_i_rdata_hold", 64'(bus.i_rdata), 64'h1300_0000);
    wait_idle("t2_idle", 20);

    // Stray done while idle
    ack0 = ack_cnt;
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    check_eq("t3_no_busy", 64'(bus.busy), 64'd0);
    tick(3);
    check_eq("t3_no_ack", 64'(ack_cnt), 64'(ack0));

    // Both held: D,D,D,D,I repeating
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push_x(1, 0, D_CMD4, 6'd8, 32'd0);
      push_x(0, 0, I_CMD, 6'd32, 32'd0);
    end
    base = start_cnt;
    bus.i_req = 1; bus.i_cmd_addr = I_CMD; bus.i_len = 6'd32;
    bus.d_req = 1; bus.d_we = 0; bus.d_cmd_addr = D_CMD4; bus.d_len = 6'd8; bus.d_wdata = 0;
    wait_starts("t4_ten_grants", base + 10, 400);
    bus.i_req = 0; bus.d_req = 0;
    wait_idle("t4_idle", 30);
    tick(6);
    check_eq("t4_grant_count", 64'(start_cnt), 64'(base + 10));

    // Data request dropped while busy
    push_x(1, 0, D_CMD5, 6'd24, 32'd0);
    base = start_cnt;
    ack0 = ack_cnt;
    bus.d_req = 1; bus.d_cmd_addr = D_CMD5; bus.d_len = 6'd24;
    wait_starts("t5_start", base + 1, 10);
    @(negedge clk);
    bus.d_req = 0;
    check_eq("t5_busy", 64'(bus.busy), 64'd1);
    wait_ack("t5_d_ack", 1, 20);
    tick(8);
    check_eq("t5_ack_count", 64'(ack_cnt), 64'(ack0 + 1));
    check_eq("t5_no_restart", 64'(start_cnt), 64'(base + 1));

    // Reset in the middle of a transfer
    push_x(1, 0, D_CMD6, 6'd32, 32'd0);
    base = start_cnt;
    ack0 = ack_cnt;
    bus.d_req = 1; bus.d_cmd_addr = D_CMD6; bus.d_len = 6'd32;
    wait_starts("t6_start", base + 1, 10);
    @(negedge clk);
    check_eq("t6_ram_cs_low", 64'(bus.ram_cs_n), 64'd0);
    rst = 1'b1;
    bus.d_req = 0;
    @(negedge clk);
    check_eq("t6_rst_state", 64'({bus.busy, bus.i_ack, bus.d_ack, bus.spi_start,
                                  bus.flash_cs_n, bus.ram_cs_n}), 64'b000011);
    rst = 1'b0;
    tick(8);
    check_eq("t6_no_ack", 64'(ack_cnt), 64'(ack0));
    push_x(0, 0, I_CMD, 6'd32, 32'd0);
    bus.i_req = 1; bus.i_cmd_addr = I_CMD; bus.i_len = 6'd32;
    @(negedge clk);
    check_eq("t6_fresh_start", 64'(bus.spi_start), 64'd1);
    wait_ack("t6_i_ack", 0, 20);
    bus.i_req = 0;
    wait_idle("t6_idle", 20);

    // Strict priority instance: instruction never granted
    b2.i_req = 1; b2.i_cmd_addr = I_CMD; b2.i_len = 6'd32;
    b2.d_req = 1; b2.d_cmd_addr = D_CMD7; b2.d_len = 6'd16;
    for (int k = 0; k < 300 && (i2_starts + d2_starts) < 6; k++) @(negedge clk);
    b2.i_req = 0; b2.d_req = 0;
    tick(20);
    check_eq("t7_d_grants", 64'(d2_starts >= 6), 64'd1);
    check_eq("t7_i_grants", 64'(i2_starts), 64'd0);
    check_eq("t7_i_acks", 64'(i2_acks), 64'd0);
    check_eq("t7_idle", 64'(b2.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
